test_pattern_top: RTL and testbench

Parametrised multi-channel test-pattern source that drives a ready/valid stream for board bring-up and top-level simulation. It supersedes the fixed single-output test top: it adds configurable data width, channel count, packet framing, inter-packet gaps and selectable pattern modes. It sits at the top of a design under test and feeds any downstream stream sink.

---
 rtl/test_pattern_top.sv | 135 +++++++++++++
 tb/tb_test_pattern_top.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/test_pattern_top.sv
// test_pattern_top: multi-channel ready/valid test-pattern source with packet framing,
// inter-packet gaps and counter/LFSR/walking-one/constant pattern modes.
module test_pattern_top #(
  parameter int DSIZE = 8,
  parameter int CH_NUM = 4,
  parameter int LSIZE = 16,
  parameter logic [DSIZE-1:0] TAPS = DSIZE'(8'hB8),
  localparam int CW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic             sys_clock,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [DSIZE-1:0] seed,
  input  logic [LSIZE-1:0] pkt_len,
  input  logic [LSIZE-1:0] pkt_num,
  input  logic [7:0]       gap,
  input  logic             stop,
  output logic [DSIZE-1:0] odata,
  output logic             ovalid,
  output logic             olast,
  output logic [CW-1:0]    ochannel,
  input  logic             oready,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;
  state_t           state_q;
  logic [1:0]       mode_q;
  logic [DSIZE-1:0] seed_q, odata_q;
  logic [LSIZE-1:0] len_q, num_q, beat_q, pkt_q;
  logic [7:0]       gap_q, gcnt_q;
  logic [CW-1:0]    ch_q;
  logic             ovalid_q, olast_q, busy_q, done_q;
  logic [LSIZE-1:0] len_d, beat_d, pkt_d;
  logic [CW-1:0]    ch_d;
  logic             fin_d;
  // LFSR and walking-one would lock up on an all-zero seed, so it is loaded as 1
  function automatic logic [DSIZE-1:0] load_f(input logic [1:0] m, input logic [DSIZE-1:0] s);
    return (s == '0 && (m == 2'd1 || m == 2'd2)) ? DSIZE'(1) : s;
  endfunction
  function automatic logic [DSIZE-1:0] next_f(input logic [1:0] m, input logic [DSIZE-1:0] d);
    return m == 2'd0 ? d + DSIZE'(1) :
           m == 2'd1 ? {d[DSIZE-2:0], ^(d & TAPS)} :
           m == 2'd2 ? {d[DSIZE-2:0], d[DSIZE-1]} : d;
  endfunction
  assign len_d  = pkt_len == '0 ? LSIZE'(1) : pkt_len;
  assign beat_d = beat_q + LSIZE'(1);
  assign pkt_d  = pkt_q + LSIZE'(1);
  assign ch_d   = ch_q == CW'(CH_NUM - 1) ? '0 : ch_q + CW'(1);
  assign fin_d  = (num_q != '0 && pkt_d == num_q) || stop;
  always_ff @(posedge sys_clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mode_q   <= '0;
      seed_q   <= '0;
      len_q    <= '0;
      num_q    <= '0;
      gap_q    <= '0;
      gcnt_q   <= '0;
      beat_q   <= '0;
      pkt_q    <= '0;
      ch_q     <= '0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      olast_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          mode_q   <= mode;
          seed_q   <= seed;
          len_q    <= len_d;
          num_q    <= pkt_num;
          gap_q    <= gap;
          beat_q   <= '0;
          pkt_q    <= '0;
          ch_q     <= '0;
          odata_q  <= load_f(mode, seed);
          ovalid_q <= 1'b1;
          olast_q  <= len_d == LSIZE'(1);
          busy_q   <= 1'b1;
          state_q  <= RUN;
        end
        RUN: if (ovalid_q && oready) begin
          if (olast_q) begin
            beat_q  <= '0;
            pkt_q   <= pkt_d;
            ch_q    <= ch_d;
            odata_q <= load_f(mode_q, seed_q);
            olast_q <= len_q == LSIZE'(1);
            if (fin_d) begin
              ovalid_q <= 1'b0;
              olast_q  <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else if (gap_q != '0) begin
              ovalid_q <= 1'b0;
              olast_q  <= 1'b0;
              gcnt_q   <= gap_q;
              state_q  <= GAP;
            end
          end else begin
            beat_q  <= beat_d;
            odata_q <= next_f(mode_q, odata_q);
            olast_q <= beat_d == len_q - LSIZE'(1);
          end
        end
        GAP: if (stop) begin
          done_q  <= 1'b1;
          state_q <= DONE;
        end else if (gcnt_q == 8'd1) begin
          ovalid_q <= 1'b1;
          olast_q  <= len_q == LSIZE'(1);
          state_q  <= RUN;
        end else begin
          gcnt_q <= gcnt_q - 8'd1;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign odata    = odata_q;
  assign ovalid   = ovalid_q;
  assign olast    = olast_q;
  assign ochannel = ch_q;
  assign busy     = busy_q;
  assign done     = done_q;
endmodule

// File: tb/tb_test_pattern_top.sv
// tb_test_pattern_top: directed and randomized runs of test_pattern_top checked against
// an arithmetic model of the expected beat stream.
module tb_test_pattern_top;
  logic        clk = 1'b0;
  logic        rst_n, start, stop, oready;
  logic [1:0]  mode;
  logic [7:0]  seed, gap;
  logic [15:0] pkt_len, pkt_num;
  logic [7:0]  odata;
  logic        ovalid, olast, busy, done;
  logic [1:0]  ochannel;
  int          npass = 0, nchk = 0;
  logic [1:0]  rm;
  logic [7:0]  rs, rg;
  logic [15:0] rl, rn;

  test_pattern_top dut (
    .sys_clock(clk), .rst_n(rst_n), .start(start), .mode(mode), .seed(seed),
    .pkt_len(pkt_len), .pkt_num(pkt_num), .gap(gap), .stop(stop),
    .odata(odata), .ovalid(ovalid), .olast(olast), .ochannel(ochannel),
    .oready(oready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // k-th beat of a packet, computed directly from the pattern definition
  function automatic logic [7:0] gen(input logic [1:0] m, input logic [7:0] s, input int k);
    logic [7:0] v;
    int r;
    v = (s == 8'h00 && (m == 2'd1 || m == 2'd2)) ? 8'h01 : s;
    r = k % 8;
    if (m == 2'd0) return v + 8'(k);
    if (m == 2'd3) return v;
    if (m == 2'd2) return 8'((v << r) | (v >> ((8 - r) % 8)));
    for (int i = 0; i < k; i++) v = {v[6:0], ^(v & 8'hB8)};
    return v;
  endfunction

  task automatic do_run(input logic [1:0] m, input logic [7:0] s, input logic [15:0] len,
                        input logic [15:0] num, input logic [7:0] g, input int stall,
                        input int stop_pkt, input int stop_beat);
    logic [7:0] ed[$];
    logic       el[$];
    logic [1:0] ec[$];
    bit         pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int  le, npk, total, stop_idx, got, cyc, last_hs, idle;
    bit  fin, prev_stall, pkt_end;
    logic [7:0] pd;
    logic       pl;
    logic [1:0] pc;
    le = (len == 0) ? 1 : int'(len);
    npk = (num != 0) ? int'(num) : stop_pkt;
    total = le * npk;
    stop_idx = (stop_pkt - 1) * le + stop_beat - 1;
    for (int p = 0; p < npk; p++)
      for (int k = 0; k < le; k++) begin
        ed.push_back(gen(m, s, k));
        el.push_back(k == le - 1);
        ec.push_back(2'(p % 4));
      end
    @(negedge clk);
    mode = m; seed = s; pkt_len = len; pkt_num = num; gap = g; start = 1'b1; oready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_valid", ovalid, 1);
    check("start_busy", busy, 1);
    got = 0; cyc = 0; last_hs = -10; idle = 0; fin = 0; prev_stall = 0; pkt_end = 0;
    pd = '0; pl = 0; pc = '0;
    while (!fin && cyc < 4000) begin
      if (done) begin
        check("done_latency", cyc, last_hs + 1);
        check("beat_count", got, total);
        check("done_busy", busy, 1);
        check("done_valid", ovalid, 0);
        fin = 1;
      end else begin
        if (prev_stall) begin
          check("hold_valid", ovalid, 1);
          check("hold_data", odata, pd);
          check("hold_last", olast, pl);
          check("hold_chan", ochannel, pc);
        end
        if (stop_pkt > 0 && ovalid && got == stop_idx) stop = 1'b1;
        oready = stall == 0 ? 1'b1 : stall == 1 ? pat[cyc % 4] : 1'($urandom_range(0, 1));
        if (ovalid) begin
          if (pkt_end) begin
            check("gap_idle", idle, g);
            pkt_end = 0;
          end
          if (oready) begin
            if (got < total) begin
              check("data", odata, ed[got]);
              check("last", olast, el[got]);
              check("chan", ochannel, ec[got]);
            end else check("extra_beat", got, total - 1);
            pkt_end = olast;
            got++;
            last_hs = cyc;
            idle = 0;
          end
        end else idle++;
        prev_stall = ovalid && !oready;
        pd = odata; pl = olast; pc = ochannel;
        @(negedge clk);
        cyc++;
      end
    end
    check("run_timeout", fin, 1);
    stop = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("post_busy", busy, 0);
    check("post_valid", ovalid, 0);
    @(negedge clk);
    check("ignored_start", ovalid, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; oready = 1'b0;
    mode = '0; seed = '0; pkt_len = '0; pkt_num = '0; gap = '0;
    repeat (3) @(negedge clk);
    check("rst_data", odata, 0);
    check("rst_valid", ovalid, 0);
    check("rst_last", olast, 0);
    check("rst_chan", ochannel, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    do_run(2'd0, 8'hFE, 16'd4, 16'd2, 8'd0, 0, 0, 0);
    do_run(2'd0, 8'hFE, 16'd4, 16'd2, 8'd0, 1, 0, 0);
    do_run(2'd0, 8'h10, 16'd1, 16'd6, 8'd3, 0, 0, 0);
    do_run(2'd1, 8'h00, 16'd6, 16'd1, 8'd0, 0, 0, 0);
    do_run(2'd2, 8'h00, 16'd9, 16'd1, 8'd0, 0, 0, 0);
    do_run(2'd0, 8'h30, 16'd5, 16'd0, 8'd0, 0, 3, 2);
    do_run(2'd3, 8'h07, 16'd0, 16'd2, 8'd1, 2, 0, 0);
    for (int i = 0; i < 6; i++) begin
      rm = 2'($urandom_range(0, 3));
      rs = 8'($urandom_range(0, 255));
      rl = 16'($urandom_range(1, 6));
      rn = 16'($urandom_range(1, 3));
      rg = 8'($urandom_range(0, 3));
      do_run(rm, rs, rl, rn, rg, 2, 0, 0);
    end
    @(negedge clk);
    mode = 2'd0; seed = 8'h40; pkt_len = 16'd8; pkt_num = 16'd1; gap = 8'd0;
    start = 1'b1; oready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_data", odata, 8'h42);
    #2 rst_n = 1'b0;
    #1;
    check("arst_data", odata, 0);
    check("arst_valid", ovalid, 0);
    check("arst_last", olast, 0);
    check("arst_chan", ochannel, 0);
    check("arst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_outs", {odata, ovalid, olast, ochannel, busy, done}, 0);
    end
    do_run(2'd0, 8'h40, 16'd3, 16'd1, 8'd0, 2, 0, 0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
